gate_sequencer: RTL and testbench

//  Shared-barrier controller for the parking lot. Arbitrates entry and exit requests onto one gate.

---
 rtl/gate_sequencer_if.sv | 25 ++
 rtl/gate_sequencer.sv | 166 ++++++++++++++++
 tb/tb_gate_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/gate_sequencer_if.sv
// Request/grant bundle between the gate sensors and the gate sequencer.
// The master side raises requests and pass pulses; the slave side returns grants.
interface gate_sequencer_if;
  logic entry_req;
  logic exit_req;
  logic car_passed;
  logic entry_grant;
  logic exit_grant;

  modport master (
    output entry_req,
    output exit_req,
    output car_passed,
    input  entry_grant,
    input  exit_grant
  );

  modport slave (
    input  entry_req,
    input  exit_req,
    input  car_passed,
    output entry_grant,
    output exit_grant
  );
endinterface

// File: rtl/gate_sequencer.sv
// Shared-barrier controller: round-robin entry/exit arbitration, open/closing timing, occupancy.
// Define OBSTACLE_SENSE_EN to add the obstacle input that reopens the gate during CLOSING.
module gate_sequencer #(
  parameter int unsigned OPEN_SECS    = 5,
  parameter int unsigned CLOSE_SECS   = 2,
  parameter int unsigned MAX_CAPACITY = 8,
  parameter int unsigned CNT_W        = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_1hz,
  input  logic             tick_2hz,
`ifdef OBSTACLE_SENSE_EN
  input  logic             obstacle,
`endif
  gate_sequencer_if.slave  gif,
  output logic             gate_open,
  output logic             warn_led,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE,
    OPEN,
    CLOSING
  } state_t;

  typedef enum logic {
    SIDE_EXIT,
    SIDE_ENTRY
  } side_t;

  state_t           state, state_n;
  side_t            last_served, last_served_n;
  logic [3:0]       timer, timer_n;
  logic [CNT_W-1:0] occupancy_n;
  logic             gate_open_n, warn_led_n;
  logic             entry_grant, entry_grant_n;
  logic             exit_grant, exit_grant_n;
  logic             eligible_entry, eligible_exit;
  logic             obstacle_hit;

`ifdef OBSTACLE_SENSE_EN
  assign obstacle_hit = obstacle;
`else
  assign obstacle_hit = 1'b0;
`endif

  assign full            = (occupancy == CNT_W'(MAX_CAPACITY));
  assign busy            = (state != IDLE);
  assign gif.entry_grant = entry_grant;
  assign gif.exit_grant  = exit_grant;
  assign eligible_entry  = gif.entry_req & ~full;
  assign eligible_exit   = gif.exit_req & (occupancy != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      last_served <= SIDE_EXIT;
      timer       <= '0;
      occupancy   <= '0;
      gate_open   <= 1'b0;
      warn_led    <= 1'b0;
      entry_grant <= 1'b0;
      exit_grant  <= 1'b0;
    end else begin
      state       <= state_n;
      last_served <= last_served_n;
      timer       <= timer_n;
      occupancy   <= occupancy_n;
      gate_open   <= gate_open_n;
      warn_led    <= warn_led_n;
      entry_grant <= entry_grant_n;
      exit_grant  <= exit_grant_n;
    end
  end

  always_comb begin
    state_n       = state;
    last_served_n = last_served;
    timer_n       = timer;
    occupancy_n   = occupancy;
    gate_open_n   = gate_open;
    warn_led_n    = warn_led;
    entry_grant_n = entry_grant;
    exit_grant_n  = exit_grant;

    unique case (state)
      IDLE: begin
        warn_led_n = 1'b0;
        if (eligible_entry || eligible_exit) begin
          // Both eligible: serve the side opposite the one served last.
          if (eligible_entry && (!eligible_exit || last_served == SIDE_EXIT)) begin
            entry_grant_n = 1'b1;
            exit_grant_n  = 1'b0;
            last_served_n = SIDE_ENTRY;
          end else begin
            entry_grant_n = 1'b0;
            exit_grant_n  = 1'b1;
            last_served_n = SIDE_EXIT;
          end
          state_n     = OPEN;
          timer_n     = 4'(OPEN_SECS);
          gate_open_n = 1'b1;
        end
      end

      OPEN: begin
        warn_led_n = 1'b0;
        // A pass coinciding with the final tick still counts, so it is checked first.
        if (gif.car_passed) begin
          if (entry_grant && occupancy != CNT_W'(MAX_CAPACITY))
            occupancy_n = occupancy + 1'b1;
          else if (exit_grant && occupancy != '0)
            occupancy_n = occupancy - 1'b1;
          state_n     = CLOSING;
          timer_n     = 4'(CLOSE_SECS);
          gate_open_n = 1'b0;
        end else if (tick_1hz) begin
          if (timer <= 4'd1) begin
            state_n     = CLOSING;
            timer_n     = 4'(CLOSE_SECS);
            gate_open_n = 1'b0;
          end else begin
            timer_n = timer - 1'b1;
          end
        end
      end

      CLOSING: begin
        gate_open_n = 1'b0;
        if (obstacle_hit) begin
          state_n     = OPEN;
          timer_n     = 4'(OPEN_SECS);
          gate_open_n = 1'b1;
          warn_led_n  = 1'b0;
        end else begin
          if (tick_2hz)
            warn_led_n = ~warn_led;
          if (tick_1hz) begin
            if (timer <= 4'd1) begin
              state_n       = IDLE;
              timer_n       = '0;
              warn_led_n    = 1'b0;
              entry_grant_n = 1'b0;
              exit_grant_n  = 1'b0;
            end else begin
              timer_n = timer - 1'b1;
            end
          end
        end
      end

      default: begin
        state_n       = IDLE;
        gate_open_n   = 1'b0;
        warn_led_n    = 1'b0;
        entry_grant_n = 1'b0;
        exit_grant_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_gate_sequencer.sv
// Directed bench for gate_sequencer with OPEN_SECS=3, CLOSE_SECS=2, MAX_CAPACITY=2.
// Covers arbitration, timeout, warning blink, full/empty guards, reset and optional obstacle reopen.
module tb_gate_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick_1hz = 1'b0;
  logic       tick_2hz = 1'b0;
  logic       gate_open, warn_led, full, busy;
  logic [3:0] occupancy;
`ifdef OBSTACLE_SENSE_EN
  logic       obstacle = 1'b0;
`endif
  int         checks = 0;
  int         errors = 0;

  gate_sequencer_if gif ();

  gate_sequencer #(
    .OPEN_SECS    (3),
    .CLOSE_SECS   (2),
    .MAX_CAPACITY (2),
    .CNT_W        (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .tick_1hz  (tick_1hz),
    .tick_2hz  (tick_2hz),
`ifdef OBSTACLE_SENSE_EN
    .obstacle  (obstacle),
`endif
    .gif       (gif.slave),
    .gate_open (gate_open),
    .warn_led  (warn_led),
    .occupancy (occupancy),
    .full      (full),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout: got no finish, required finish within 200000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick1();
    tick_1hz = 1'b1;
    cyc();
    tick_1hz = 1'b0;
  endtask

  task automatic tick2();
    tick_2hz = 1'b1;
    cyc();
    tick_2hz = 1'b0;
  endtask

  task automatic pass_pulse();
    gif.car_passed = 1'b1;
    cyc();
    gif.car_passed = 1'b0;
  endtask

  // One full gate transaction; pass=0 exercises the OPEN timeout and warning blink.
  task automatic txn(input string tag, input logic er, input logic xr,
                     input logic exp_e, input logic exp_x, input logic pass,
                     input logic [3:0] exp_occ);
    gif.entry_req = er;
    gif.exit_req  = xr;
    cyc();
    gif.entry_req = 1'b0;
    gif.exit_req  = 1'b0;
    check({tag, " gate_open"}, gate_open, 1);
    check({tag, " entry_grant"}, gif.entry_grant, exp_e);
    check({tag, " exit_grant"}, gif.exit_grant, exp_x);
    if (pass) begin
      tick1();
      check({tag, " open after 1 tick"}, gate_open, 1);
      pass_pulse();
      check({tag, " closing gate"}, gate_open, 0);
      check({tag, " occupancy"}, occupancy, exp_occ);
      pass_pulse();
      check({tag, " pass ignored in closing"}, occupancy, exp_occ);
    end else begin
      tick1();
      tick1();
      check({tag, " open after 2 ticks"}, gate_open, 1);
      tick1();
      check({tag, " timeout closes"}, gate_open, 0);
      check({tag, " timeout occupancy"}, occupancy, exp_occ);
      tick2();
      check({tag, " warn 1st toggle"}, warn_led, 1);
      tick2();
      check({tag, " warn 2nd toggle"}, warn_led, 0);
      tick2();
      check({tag, " warn 3rd toggle"}, warn_led, 1);
    end
    tick1();
    check({tag, " busy mid closing"}, busy, 1);
    tick1();
    check({tag, " idle busy"}, busy, 0);
    check({tag, " idle warn"}, warn_led, 0);
    check({tag, " idle grants"}, {gif.entry_grant, gif.exit_grant}, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " outputs"},
          {gate_open, warn_led, gif.entry_grant, gif.exit_grant, full, busy}, 0);
    check({tag, " occupancy"}, occupancy, 0);
  endtask

  initial begin
    gif.entry_req  = 1'b0;
    gif.exit_req   = 1'b0;
    gif.car_passed = 1'b0;
    cyc();
    cyc();
    check_all_zero("reset");
    reset = 1'b1;
    cyc();

    // T1: entry, pass after one tick, close over two ticks.
    txn("t1", 1, 0, 1, 0, 1, 4'd1);
    txn("entry2", 1, 0, 1, 0, 1, 4'd2);
    check("full at capacity", full, 1);

    // T4: entry refused while full.
    gif.entry_req = 1'b1;
    cyc();
    gif.entry_req = 1'b0;
    check("full no grant", {gate_open, gif.entry_grant, gif.exit_grant}, 0);
    check("full busy", busy, 0);

    txn("exit1", 0, 1, 0, 1, 1, 4'd1);
    // T2: both eligible after an exit -> entry, then exit (full leaves exit only).
    txn("t2 rr entry", 1, 1, 1, 0, 1, 4'd2);
    txn("t2 exit", 1, 1, 0, 1, 1, 4'd1);
    // T3: both eligible, last served exit -> entry, timeout without pass.
    txn("t3 timeout", 1, 1, 1, 0, 0, 4'd1);
    // Both eligible, last served entry -> exit.
    txn("rr exit", 1, 1, 0, 1, 1, 4'd0);

    // T4 cont.: exit refused while empty.
    gif.exit_req = 1'b1;
    cyc();
    gif.exit_req = 1'b0;
    check("empty no grant", {gate_open, gif.entry_grant, gif.exit_grant, busy}, 0);

    // T5 cont.: pass coincident with final OPEN tick is counted.
    gif.entry_req = 1'b1;
    cyc();
    gif.entry_req = 1'b0;
    tick1();
    tick1();
    check("coincide still open", gate_open, 1);
    tick_1hz = 1'b1;
    gif.car_passed = 1'b1;
    cyc();
    tick_1hz = 1'b0;
    gif.car_passed = 1'b0;
    check("coincide counted", occupancy, 1);
    check("coincide closing", {gate_open, busy}, 2'b01);
    tick1();
    tick1();
    check("coincide idle", busy, 0);

    // T5: reset in the middle of OPEN.
    gif.entry_req = 1'b1;
    cyc();
    gif.entry_req = 1'b0;
    check("pre-reset open", gate_open, 1);
    reset = 1'b0;
    cyc();
    check_all_zero("mid-open reset");
    reset = 1'b1;
    cyc();

`ifdef OBSTACLE_SENSE_EN
    // T6: obstacle in CLOSING reopens with a fresh OPEN timer.
    gif.entry_req = 1'b1;
    cyc();
    gif.entry_req = 1'b0;
    pass_pulse();
    tick2();
    check("obst warn before", warn_led, 1);
    obstacle = 1'b1;
    cyc();
    obstacle = 1'b0;
    check("obst reopen", gate_open, 1);
    check("obst warn cleared", warn_led, 0);
    check("obst grant held", gif.entry_grant, 1);
    tick1();
    tick1();
    check("obst timer full", gate_open, 1);
    tick1();
    check("obst timeout", gate_open, 0);
    check("obst occupancy", occupancy, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
